// File: rtl/morph_open_stream_if.sv
// Pixel-stream bundle for the 3x3 binary morphology filter.
// Handshake: a pixel moves only on a rising clock edge where iDVAL=1 (no back-pressure);
// an output pixel is present exactly on cycles where oDVAL=1, and oDATA/oFRAME_END are 0 otherwise.
interface morph_open_stream_if;
  logic iDVAL;
  logic iDATA;
  logic iMODE;
  logic iBYPASS;
  logic oDVAL;
  logic oDATA;
  logic oFRAME_END;
  logic oOVF;
  logic dbg_flush;   // 1 while the filter is draining the last W+1 pixels of a frame

  modport slave (
    input  iDVAL, iDATA, iMODE, iBYPASS,
    output oDVAL, oDATA, oFRAME_END, oOVF, dbg_flush
  );

  modport master (
    output iDVAL, iDATA, iMODE, iBYPASS,
    input  oDVAL, oDATA, oFRAME_END, oOVF, dbg_flush
  );
endinterface

// File: rtl/morph_open_stream.sv
// 3x3 binary erode/dilate on a raster-order skin-mask stream.
// The last 2W+2 accepted pixels sit in one shift chain (two line buffers plus the
// window taps), so the window for output j=k-W-1 is complete when pixel k arrives.
// After the last pixel of a frame, W+1 zero pixels are shifted in internally to
// drain the remaining outputs; out-of-frame neighbours are masked to 0.
module morph_open_stream #(
  parameter int W = 320,
  parameter int H = 240
) (
  input  logic               iCLK,
  input  logic               iRST,
  morph_open_stream_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int FW = $clog2(W + 1);
  localparam int L  = 2 * W + 2;

  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);
  localparam logic [FW-1:0] FL_MAX  = FW'(W);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [L-1:0]  sr_q, sr_d;
  logic [CW-1:0] in_col_q, in_col_d;
  logic [RW-1:0] in_row_q, in_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [FW-1:0] fl_cnt_q, fl_cnt_d;
  logic          mode_q, mode_d;
  logic          byp_q, byp_d;
  logic          dval_q, dval_d;
  logic          data_q, data_d;
  logic          fend_q, fend_d;
  logic          ovf_q, ovf_d;

  logic          new_pix;
  logic [8:0]    nb;
  logic [8:0]    present;
  logic          filt;

  // Window taps around centre (out_row, out_col) and the filtered result.
  always_comb begin
    nb      = '0;
    present = '0;
    filt    = 1'b0;
    // row above: up-left, up, up-right
    nb[8] = sr_q[2*W+1];
    nb[7] = sr_q[2*W];
    nb[6] = sr_q[2*W-1];
    // own row: left, centre, right
    nb[5] = sr_q[W+1];
    nb[4] = sr_q[W];
    nb[3] = sr_q[W-1];
    // row below: down-left, down, down-right (the pixel arriving now)
    nb[2] = sr_q[1];
    nb[1] = sr_q[0];
    nb[0] = new_pix;
    present[8] = (out_row_q != '0)     && (out_col_q != '0);
    present[7] = (out_row_q != '0);
    present[6] = (out_row_q != '0)     && (out_col_q != COL_MAX);
    present[5] = (out_col_q != '0);
    present[4] = 1'b1;
    present[3] = (out_col_q != COL_MAX);
    present[2] = (out_row_q != ROW_MAX) && (out_col_q != '0);
    present[1] = (out_row_q != ROW_MAX);
    present[0] = (out_row_q != ROW_MAX) && (out_col_q != COL_MAX);
    if (byp_q) begin
      filt = nb[4];
    end else if (mode_q) begin
      filt = |(nb & present);
    end else begin
      filt = (&present) & (&nb);
    end
  end

  // Next-state: input counting, frame-end flush sequencing and output generation.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    fl_cnt_d  = fl_cnt_q;
    mode_d    = mode_q;
    byp_d     = byp_q;
    dval_d    = 1'b0;
    data_d    = 1'b0;
    fend_d    = 1'b0;
    ovf_d     = 1'b0;
    new_pix   = 1'b0;

    case (state_q)
      S_RUN: begin
        if (bus.iDVAL) begin
          new_pix = bus.iDATA;
          sr_d    = {sr_q[L-2:0], bus.iDATA};
          if ((in_col_q == '0) && (in_row_q == '0)) begin
            mode_d = bus.iMODE;
            byp_d  = bus.iBYPASS;
          end
          // Pixels 0..W have no complete window yet; from pixel W+1 on, one output each.
          if ((in_row_q != '0) && ((in_row_q != RW'(1)) || (in_col_q != '0))) begin
            dval_d = 1'b1;
          end
          if (in_col_q == COL_MAX) begin
            in_col_d = '0;
            if (in_row_q == ROW_MAX) begin
              in_row_d = '0;
              state_d  = S_FLUSH;
              fl_cnt_d = '0;
            end else begin
              in_row_d = in_row_q + RW'(1);
            end
          end else begin
            in_col_d = in_col_q + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        // Inputs arriving while draining are dropped and flagged.
        ovf_d    = bus.iDVAL;
        new_pix  = 1'b0;
        sr_d     = {sr_q[L-2:0], 1'b0};
        dval_d   = 1'b1;
        fl_cnt_d = fl_cnt_q + FW'(1);
        if (fl_cnt_q == FL_MAX) begin
          state_d = S_RUN;
          sr_d    = '0;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (dval_d) begin
      data_d = filt;
      fend_d = (out_row_q == ROW_MAX) && (out_col_q == COL_MAX);
      if (out_col_q == COL_MAX) begin
        out_col_d = '0;
        out_row_d = (out_row_q == ROW_MAX) ? '0 : out_row_q + RW'(1);
      end else begin
        out_col_d = out_col_q + CW'(1);
      end
    end
  end

  // State, line-buffer chain and registered outputs.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= S_RUN;
      sr_q      <= '0;
      in_col_q  <= '0;
      in_row_q  <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      fl_cnt_q  <= '0;
      mode_q    <= 1'b0;
      byp_q     <= 1'b0;
      dval_q    <= 1'b0;
      data_q    <= 1'b0;
      fend_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
      fl_cnt_q  <= fl_cnt_d;
      mode_q    <= mode_d;
      byp_q     <= byp_d;
      dval_q    <= dval_d;
      data_q    <= data_d;
      fend_q    <= fend_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.oDVAL      = dval_q;
  assign bus.oDATA      = data_q;
  assign bus.oFRAME_END = fend_q;
  assign bus.oOVF       = ovf_q;
  assign bus.dbg_flush  = (state_q == S_FLUSH);

endmodule
